mem_bus_bridge: RTL and testbench

MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

---
 rtl/mem_bus_bridge_if.sv | 30 +++
 rtl/mem_bus_bridge.sv | 168 ++++++++++++++++
 tb/tb_mem_bus_bridge.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_bridge_if.sv
// Signal bundle between the core byte bus, the host pad link and the bridge.
interface mem_bus_bridge_if;
  logic       bus_pc;
  logic       bus_mar;
  logic       bus_mdr;
  logic [7:0] core_out;
  logic [7:0] core_in;
  logic       data_ready;
  logic       receive_ready;
  logic [7:0] pad_out;
  logic       pad_strobe;
  logic       pad_ack;
  logic [7:0] pad_in;
  logic       pad_valid;
  logic       pad_rx_ready;
  logic       ovf_err;
  logic       sel_err;

  modport slave (
    input  bus_pc, bus_mar, bus_mdr, core_out, pad_ack, pad_in, pad_valid,
    output core_in, data_ready, receive_ready, pad_out, pad_strobe,
           pad_rx_ready, ovf_err, sel_err
  );

  modport master (
    output bus_pc, bus_mar, bus_mdr, core_out, pad_ack, pad_in, pad_valid,
    input  core_in, data_ready, receive_ready, pad_out, pad_strobe,
           pad_rx_ready, ovf_err, sel_err
  );
endinterface

// File: rtl/mem_bus_bridge.sv
// Core byte bus <-> host pad bridge: tagged 4-entry outbound FIFO with framed TX, single-byte RX.
// Optional trailing checksum byte per frame when BRIDGE_CHECKSUM_EN is defined.
//
// state  | meaning
// IDLE   | nothing on the pad, waiting for a FIFO entry
// HDR    | presenting frame header 8'hA0|tag
// DATA   | presenting the FIFO head byte, popped on ack
// CSUM   | presenting header^byte0^byte1 (checksum build only)
module mem_bus_bridge (
  input  logic            clk,
  input  logic            rst,
  mem_bus_bridge_if.slave bus
);
`ifdef BRIDGE_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_CSUM} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;
`endif

  state_t      r_state, w_state_nxt;
  logic [10:0] r_fifo [4];
  logic [1:0]  r_rd_ptr, r_wr_ptr, r_last_tag;
  logic [2:0]  r_count, w_count_nxt;
  logic [7:0]  r_pad_out, w_pad_out_nxt, r_core_in;
  logic        r_pad_strobe, w_pad_strobe_nxt;
  logic        r_recv_ready, r_ovf_err, r_sel_err, r_data_ready, r_rx_ready;
`ifdef BRIDGE_CHECKSUM_EN
  logic [7:0]  r_csum, w_csum_nxt;
`endif

  logic [1:0]  w_sel_cnt, w_tag;
  logic        w_one_sel, w_multi_sel, w_sof, w_xfer, w_pop, w_push, w_drop, w_capture;
  logic [10:0] w_head, w_launch;
  logic        w_launch_ok;

  assign w_sel_cnt   = {1'b0, bus.bus_pc} + {1'b0, bus.bus_mar} + {1'b0, bus.bus_mdr};
  assign w_one_sel   = (w_sel_cnt == 2'd1);
  assign w_multi_sel = (w_sel_cnt >= 2'd2);
  assign w_tag       = bus.bus_pc ? 2'b01 : (bus.bus_mar ? 2'b10 : 2'b11);
  assign w_sof       = (w_tag != r_last_tag);
  assign w_xfer      = r_pad_strobe & bus.pad_ack;
  assign w_head      = r_fifo[r_rd_ptr];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push      = w_one_sel & ((r_count != 3'd4) | w_pop);
  assign w_drop      = w_one_sel & (r_count == 3'd4) & ~w_pop;
  assign w_count_nxt = r_count + {2'b00, w_push} - {2'b00, w_pop};
  assign w_capture   = bus.pad_valid & r_rx_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_pad_out_nxt    = r_pad_out;
    w_pad_strobe_nxt = r_pad_strobe;
    w_pop            = 1'b0;
    w_launch         = w_head;
    w_launch_ok      = 1'b0;
`ifdef BRIDGE_CHECKSUM_EN
    w_csum_nxt       = r_csum;
`endif
    case (r_state)
      S_IDLE: w_launch_ok = (r_count != 3'd0);
      S_HDR: begin
        if (w_xfer) begin
          w_state_nxt   = S_DATA;
          w_pad_out_nxt = w_head[7:0];
        end
      end
      S_DATA: begin
        if (w_xfer) begin
          w_pop = 1'b1;
`ifdef BRIDGE_CHECKSUM_EN
          w_csum_nxt = r_csum ^ w_head[7:0];
          if (!w_head[10]) begin
            w_state_nxt   = S_CSUM;
            w_pad_out_nxt = r_csum ^ w_head[7:0];
          end else begin
            w_launch         = r_fifo[r_rd_ptr + 2'd1];
            w_launch_ok      = (r_count >= 3'd2);
            w_state_nxt      = S_IDLE;
            w_pad_strobe_nxt = 1'b0;
          end
`else
          w_launch         = r_fifo[r_rd_ptr + 2'd1];
          w_launch_ok      = (r_count >= 3'd2);
          w_state_nxt      = S_IDLE;
          w_pad_strobe_nxt = 1'b0;
`endif
        end
      end
`ifdef BRIDGE_CHECKSUM_EN
      S_CSUM: begin
        if (w_xfer) begin
          w_launch_ok      = (r_count != 3'd0);
          w_state_nxt      = S_IDLE;
          w_pad_strobe_nxt = 1'b0;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase

    // Start presenting the next entry without an idle bubble when one is already queued.
    if (w_launch_ok) begin
      w_pad_strobe_nxt = 1'b1;
      if (w_launch[10]) begin
        w_state_nxt   = S_HDR;
        w_pad_out_nxt = 8'hA0 | {6'd0, w_launch[9:8]};
`ifdef BRIDGE_CHECKSUM_EN
        w_csum_nxt    = 8'hA0 | {6'd0, w_launch[9:8]};
`endif
      end else begin
        w_state_nxt   = S_DATA;
        w_pad_out_nxt = w_launch[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {w_sof, w_tag, bus.core_out};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rd_ptr     <= 2'd0;
      r_wr_ptr     <= 2'd0;
      r_count      <= 3'd0;
      r_last_tag   <= 2'd0;
      r_pad_out    <= 8'd0;
      r_pad_strobe <= 1'b0;
      r_recv_ready <= 1'b1;
      r_ovf_err    <= 1'b0;
      r_sel_err    <= 1'b0;
      r_core_in    <= 8'd0;
      r_data_ready <= 1'b0;
      r_rx_ready   <= 1'b1;
`ifdef BRIDGE_CHECKSUM_EN
      r_csum       <= 8'd0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_pad_out    <= w_pad_out_nxt;
      r_pad_strobe <= w_pad_strobe_nxt;
      r_count      <= w_count_nxt;
      r_recv_ready <= (w_count_nxt <= 3'd2);
      r_last_tag   <= w_one_sel ? w_tag : 2'b00;
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      if (w_drop) r_ovf_err <= 1'b1;
      if (w_multi_sel) r_sel_err <= 1'b1;
      r_data_ready <= w_capture;
      r_rx_ready   <= ~w_capture;
      if (w_capture) r_core_in <= bus.pad_in;
`ifdef BRIDGE_CHECKSUM_EN
      r_csum       <= w_csum_nxt;
`endif
    end
  end

  assign bus.pad_out       = r_pad_out;
  assign bus.pad_strobe    = r_pad_strobe;
  assign bus.receive_ready = r_recv_ready;
  assign bus.ovf_err       = r_ovf_err;
  assign bus.sel_err       = r_sel_err;
  assign bus.core_in       = r_core_in;
  assign bus.data_ready    = r_data_ready;
  assign bus.pad_rx_ready  = r_rx_ready;
endmodule

// File: tb/tb_mem_bus_bridge.sv
// Scoreboard bench for mem_bus_bridge: a frame-level predictor fills expected queues, monitors drain them.
`timescale 1ns/1ps
module tb_mem_bus_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  mem_bus_bridge_if bif();
  mem_bus_bridge dut (.clk(clk), .rst(rst), .bus(bif));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] val; bit pops; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] rx_q[$];
  exp_t       mon_e;
  bit         pop_now = 1'b0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_out = 8'd0;

  // reference model state
  int         occ = 0;
  int         last_sel = 0;
  int         nsel, cur;
  logic [7:0] cs = 8'd0;
  logic [7:0] hdr;
  bit         m_ovf = 0, m_sel = 0, m_rx_ready = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic exp_t item(input logic [7:0] v, input bit p);
    exp_t e;
    e.val = v;
    e.pops = p;
    return e;
  endfunction

  // Monitor: compares every completed pad handshake and every RX strobe against the queues.
  always @(negedge clk) begin
    pop_now = 1'b0;
    if (rst === 1'b0) begin
      if (prev_hold) check("strobe_hold", {23'd0, bif.pad_strobe, bif.pad_out}, {23'd0, 1'b1, prev_out});
      if (bif.pad_strobe === 1'b1 && bif.pad_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected: got byte %0h, required no transfer", bif.pad_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("tx_byte", {24'd0, bif.pad_out}, {24'd0, mon_e.val});
          pop_now = mon_e.pops;
        end
      end
    end
    if (bif.data_ready === 1'b1) begin
      if (rx_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected: got byte %0h, required no strobe", bif.core_in);
      end else begin
        check("rx_byte", {24'd0, bif.core_in}, {24'd0, rx_q.pop_front()});
      end
    end
    prev_hold = (rst === 1'b0) && bif.pad_strobe === 1'b1 && bif.pad_ack === 1'b0;
    prev_out  = bif.pad_out;
  end

  // Predictor: turns each cycle's inputs into expected pad bytes, flags and RX bytes.
  always @(negedge clk) begin
    #1;
    if (rst !== 1'b0) begin
      exp_q.delete();
      rx_q.delete();
      occ = 0; last_sel = 0; cs = 8'd0;
      m_ovf = 0; m_sel = 0; m_rx_ready = 1;
    end else begin
      check("receive_ready", {31'd0, bif.receive_ready}, {31'd0, (occ <= 2)});
      check("ovf_err", {31'd0, bif.ovf_err}, {31'd0, m_ovf});
      check("sel_err", {31'd0, bif.sel_err}, {31'd0, m_sel});
      check("pad_rx_ready", {31'd0, bif.pad_rx_ready}, {31'd0, m_rx_ready});
      nsel = int'(bif.bus_pc) + int'(bif.bus_mar) + int'(bif.bus_mdr);
      cur = (nsel != 1) ? 0 : (bif.bus_pc ? 1 : (bif.bus_mar ? 2 : 3));
      if (nsel >= 2) m_sel = 1;
      if (nsel == 1) begin
        if (occ < 4 || pop_now) begin
          if (cur != last_sel) begin
            hdr = 8'hA0 | 8'(cur);
            exp_q.push_back(item(hdr, 1'b0));
            cs = hdr ^ bif.core_out;
            exp_q.push_back(item(bif.core_out, 1'b1));
          end else begin
            cs = cs ^ bif.core_out;
            exp_q.push_back(item(bif.core_out, 1'b1));
`ifdef BRIDGE_CHECKSUM_EN
            exp_q.push_back(item(cs, 1'b0));
`endif
          end
          occ++;
        end else begin
          m_ovf = 1;
        end
      end
      if (pop_now) occ--;
      last_sel = cur;
      if (bif.pad_valid && m_rx_ready) begin
        rx_q.push_back(bif.pad_in);
        m_rx_ready = 0;
      end else begin
        m_rx_ready = 1;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    bif.bus_pc = 0; bif.bus_mar = 0; bif.bus_mdr = 0; bif.pad_valid = 0;
    bif.pad_ack = 1;
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
    tick(3);
    check(name, exp_q.size(), 0);
  endtask

  int r;
  int sel_pick = 1;

  initial begin
    bif.bus_pc = 0; bif.bus_mar = 0; bif.bus_mdr = 0; bif.core_out = 8'd0;
    bif.pad_ack = 0; bif.pad_in = 8'd0; bif.pad_valid = 0;
    tick(3);
    rst = 1'b0;
    check("rst_pad_strobe", {31'd0, bif.pad_strobe}, 0);
    check("rst_pad_out", {24'd0, bif.pad_out}, 0);
    check("rst_core_in", {24'd0, bif.core_in}, 0);
    check("rst_data_ready", {31'd0, bif.data_ready}, 0);
    check("rst_pad_rx_ready", {31'd0, bif.pad_rx_ready}, 1);
    check("rst_receive_ready", {31'd0, bif.receive_ready}, 1);
    check("rst_ovf_err", {31'd0, bif.ovf_err}, 0);
    check("rst_sel_err", {31'd0, bif.sel_err}, 0);

    // two-byte PC frame with ack tied high: A1,12,34
    bif.pad_ack = 1;
    bif.bus_pc = 1; bif.core_out = 8'h12;
    tick();
    bif.core_out = 8'h34;
    tick();
    drain("pc_frame_drain");

    // two selects at once
    bif.bus_mar = 1; bif.bus_mdr = 1; bif.core_out = 8'hFF;
    tick();
    bif.bus_mar = 0; bif.bus_mdr = 0;
    tick(3);
    check("multi_sel_err", {31'd0, bif.sel_err}, 1);
    check("multi_sel_strobe", {31'd0, bif.pad_strobe}, 0);
    check("multi_sel_no_push", exp_q.size(), 0);

    // overflow with ack held low
    do_reset();
    bif.pad_ack = 0;
    bif.bus_mdr = 1;
    for (int i = 1; i <= 3; i++) begin
      bif.core_out = 8'(i);
      tick();
    end
    check("ovf_rr_after3", {31'd0, bif.receive_ready}, 0);
    for (int i = 4; i <= 6; i++) begin
      bif.core_out = 8'(i);
      tick();
    end
    bif.bus_mdr = 0;
    tick();
    check("ovf_flag", {31'd0, bif.ovf_err}, 1);
    check("ovf_head_hdr", {23'd0, bif.pad_strobe, bif.pad_out}, {23'd0, 1'b1, 8'hA3});
    drain("ovf_drain");

    // full FIFO: pop and push in the same cycle
    do_reset();
    bif.pad_ack = 0;
    bif.bus_mdr = 1;
    for (int i = 0; i < 4; i++) begin
      bif.core_out = 8'h11 + 8'(i);
      tick();
    end
    bif.bus_mdr = 0;
    tick(2);
    bif.pad_ack = 1;
    tick();
    bif.pad_ack = 0;
    tick();
    check("full_data_presented", {23'd0, bif.pad_strobe, bif.pad_out}, {23'd0, 1'b1, 8'h11});
    bif.bus_pc = 1; bif.core_out = 8'h55; bif.pad_ack = 1;
    tick();
    bif.bus_pc = 0; bif.pad_ack = 0;
    check("full_pushpop_ovf", {31'd0, bif.ovf_err}, 0);
    check("full_pushpop_rr", {31'd0, bif.receive_ready}, 0);
    drain("full_drain");

    // RX single byte
    bif.pad_valid = 1; bif.pad_in = 8'h5A;
    tick();
    bif.pad_valid = 0;
    check("rx_strobe", {31'd0, bif.data_ready}, 1);
    check("rx_data", {24'd0, bif.core_in}, 8'h5A);
    check("rx_ready_low", {31'd0, bif.pad_rx_ready}, 0);
    tick();
    check("rx_strobe_one", {31'd0, bif.data_ready}, 0);
    check("rx_hold", {24'd0, bif.core_in}, 8'h5A);
    check("rx_ready_back", {31'd0, bif.pad_rx_ready}, 1);

    // reset while a header waits for ack
    do_reset();
    bif.pad_ack = 0;
    bif.bus_pc = 1; bif.core_out = 8'h77;
    tick();
    bif.bus_pc = 0;
    for (int k = 0; k < 10 && bif.pad_strobe !== 1'b1; k++) tick();
    check("hdr_wait", {23'd0, bif.pad_strobe, bif.pad_out}, {23'd0, 1'b1, 8'hA1});
    rst = 1'b1;
    tick();
    check("rst_mid_strobe", {31'd0, bif.pad_strobe}, 0);
    check("rst_mid_rr", {31'd0, bif.receive_ready}, 1);
    rst = 1'b0;
    bif.pad_ack = 1;
    tick(5);
    check("rst_mid_empty", {31'd0, bif.pad_strobe}, 0);

    // randomized traffic in both directions
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(0, 19);
      if (r < 4) sel_pick = 0;
      else if (r < 7) sel_pick = $urandom_range(1, 3);
      else if (r == 19) sel_pick = 4;
      else if (sel_pick == 0 || sel_pick == 4) sel_pick = $urandom_range(1, 3);
      bif.bus_pc  = (sel_pick == 1) || (sel_pick == 4);
      bif.bus_mar = (sel_pick == 2) || (sel_pick == 4);
      bif.bus_mdr = (sel_pick == 3);
      bif.core_out  = 8'($urandom);
      bif.pad_ack   = ($urandom_range(0, 2) != 0);
      bif.pad_valid = $urandom_range(0, 1);
      bif.pad_in    = 8'($urandom);
      tick();
    end
    drain("random_drain");
    check("random_rx_drain", rx_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
